// File: rtl/gif_seq_if.sv
// -----------------------------------------------------------------------------
// gif_seq_if
// Bundles the raster position, playback commands and frame-selection outputs
// exchanged between the display controller and the GIF frame sequencer.
//
//   h_cnt, v_cnt   raster horizontal / vertical counters (11 bits each)
//   play, pause,   1-cycle command pulses
//   stop, step
//   speed          display frames per GIF frame, minus 1
//   frame_idx      current frame number (IDX_W bits)
//   frame_base     ROM base address of the current frame (ADDR_W bits)
//   frame_tick     1-cycle pulse when frame_idx/frame_base change
//   playing        high while the sequencer is in PLAY
//
// Modports: master = display controller side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface gif_seq_if #(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 19
);
   logic [10:0]       h_cnt;
   logic [10:0]       v_cnt;
   logic              play;
   logic              pause;
   logic              stop;
   logic              step;
   logic [3:0]        speed;
   logic [IDX_W-1:0]  frame_idx;
   logic [ADDR_W-1:0] frame_base;
   logic              frame_tick;
   logic              playing;

   modport master (
      output h_cnt, v_cnt, play, pause, stop, step, speed,
      input  frame_idx, frame_base, frame_tick, playing
   );

   modport slave (
      input  h_cnt, v_cnt, play, pause, stop, step, speed,
      output frame_idx, frame_base, frame_tick, playing
   );
endinterface

// File: rtl/gif_frame_sequencer.sv
// -----------------------------------------------------------------------------
// gif_frame_sequencer
// Selects which stored GIF frame the image ROM serves by producing the frame
// base address added to the per-pixel offset by the display datapath. Frame
// changes are applied only at raster start-of-frame (h_cnt==0 && v_cnt==0),
// so a frame never switches partway through the scan.
//
// Ports:
//   clk    pixel clock (same clock as the raster counters)
//   rst_n  asynchronous active-low reset
//   bus    gif_seq_if.slave: raster counters, play/pause/stop/step pulses,
//          speed divider in; frame_idx, frame_base, frame_tick, playing out
//
// Optional feature: define GIF_PINGPONG_EN to bounce between the first and
// last frame (0,1,..,N-1,N-2,..,0,1,..) instead of wrapping to frame 0.
// -----------------------------------------------------------------------------
module gif_frame_sequencer #(
   parameter int NUM_FRAMES  = 4,
   parameter int FRAME_WORDS = 57280,
   parameter int ADDR_W      = 19,
   parameter int IDX_W       = 4,
   parameter int AUTOPLAY    = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   gif_seq_if.slave bus
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam state_t            RST_STATE   = (AUTOPLAY != 0) ? ST_PLAY : ST_STOP;
   localparam logic              RST_PLAYING = (AUTOPLAY != 0);
   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_FRAMES - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
   localparam logic [ADDR_W-1:0] FW          = ADDR_W'(FRAME_WORDS);

   state_t            state;
   logic              playing_r;
   logic [IDX_W-1:0]  frame_idx_r;
   logic [ADDR_W-1:0] frame_base_r;
   logic              frame_tick_r;
   logic [3:0]        div_cnt;
   logic              step_pend;
   logic              zero_pend;

   logic              sof;
   logic              adv_en;
   logic              zero_en;
   logic [IDX_W-1:0]  adv_idx;
   logic [ADDR_W-1:0] adv_base;

   assign sof = (bus.h_cnt == 11'd0) && (bus.v_cnt == 11'd0);

   // An advance happens at sof either when the divider has expired in PLAY or
   // when a step is pending in PAUSE; a pending zero is honoured only in STOP.
   assign adv_en  = sof && (((state == ST_PLAY) && (div_cnt >= bus.speed)) ||
                            ((state == ST_PAUSE) && step_pend));
   assign zero_en = sof && (state == ST_STOP) && zero_pend;

`ifdef GIF_PINGPONG_EN
   logic dir;      // 0 = forward, 1 = backward
   logic adv_dir;

   // Next frame when bouncing; base tracks idx by adding/subtracting one
   // frame's worth of words so no multiplier is needed.
   always_comb begin
      adv_idx  = frame_idx_r;
      adv_base = frame_base_r;
      adv_dir  = dir;
      if (NUM_FRAMES == 1) begin
         adv_idx  = '0;
         adv_base = '0;
         adv_dir  = 1'b0;
      end else if (!dir) begin
         if (frame_idx_r == LAST_IDX) begin
            adv_dir  = 1'b1;
            adv_idx  = frame_idx_r - IDX_ONE;
            adv_base = frame_base_r - FW;
         end else begin
            adv_idx  = frame_idx_r + IDX_ONE;
            adv_base = frame_base_r + FW;
         end
      end else begin
         if (frame_idx_r == '0) begin
            adv_dir  = 1'b0;
            adv_idx  = IDX_ONE;
            adv_base = FW;
         end else begin
            adv_idx  = frame_idx_r - IDX_ONE;
            adv_base = frame_base_r - FW;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir <= 1'b0;
      end else if (zero_en) begin
         dir <= 1'b0;
      end else if (adv_en) begin
         dir <= adv_dir;
      end
   end
`else
   // Next frame when wrapping: last frame returns to frame 0 / base 0.
   always_comb begin
      adv_idx  = frame_idx_r;
      adv_base = frame_base_r;
      if (frame_idx_r == LAST_IDX) begin
         adv_idx  = '0;
         adv_base = '0;
      end else begin
         adv_idx  = frame_idx_r + IDX_ONE;
         adv_base = frame_base_r + FW;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RST_STATE;
         playing_r    <= RST_PLAYING;
         frame_idx_r  <= '0;
         frame_base_r <= '0;
         frame_tick_r <= 1'b0;
         div_cnt      <= '0;
         step_pend    <= 1'b0;
         zero_pend    <= 1'b0;
      end else begin
         frame_tick_r <= 1'b0;

         // Frame update, applied only at start-of-frame.
         if (adv_en) begin
            frame_idx_r  <= adv_idx;
            frame_base_r <= adv_base;
            frame_tick_r <= 1'b1;
         end

         if (zero_en) begin
            frame_idx_r  <= '0;
            frame_base_r <= '0;
            frame_tick_r <= (frame_idx_r != '0);
            zero_pend    <= 1'b0;
         end

         // Divider runs only in PLAY; a step in PAUSE leaves it untouched.
         if (sof && (state == ST_PLAY)) begin
            if (adv_en) begin
               div_cnt <= '0;
            end else begin
               div_cnt <= div_cnt + 4'd1;
            end
         end else if (zero_en) begin
            div_cnt <= '0;
         end

         // A step consumed at this sof is cleared; a new step arriving now
         // (even in the sof cycle) is held for the following frame.
         if (sof && (state == ST_PAUSE) && step_pend) begin
            step_pend <= 1'b0;
         end
         if ((state == ST_PAUSE) && bus.step) begin
            step_pend <= 1'b1;
         end

         // Commands, priority stop > pause > play; only the top one acts.
         if (bus.stop) begin
            state     <= ST_STOP;
            playing_r <= 1'b0;
            zero_pend <= 1'b1;
            step_pend <= 1'b0;
         end else if (bus.pause) begin
            if (state == ST_PLAY) begin
               state     <= ST_PAUSE;
               playing_r <= 1'b0;
            end else if (state == ST_PAUSE) begin
               state     <= ST_PLAY;
               playing_r <= 1'b1;
               step_pend <= 1'b0;
            end
         end else if (bus.play) begin
            if (state != ST_PLAY) begin
               state     <= ST_PLAY;
               playing_r <= 1'b1;
               step_pend <= 1'b0;
            end
         end
      end
   end

   assign bus.frame_idx  = frame_idx_r;
   assign bus.frame_base = frame_base_r;
   assign bus.frame_tick = frame_tick_r;
   assign bus.playing    = playing_r;

endmodule

// File: tb/tb_gif_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gif_frame_sequencer
// Directed bench for gif_frame_sequencer (NUM_FRAMES=4, FRAME_WORDS=57280,
// AUTOPLAY=1). Raster counters are driven directly so each start-of-frame is
// a single cycle with h_cnt==v_cnt==0. Expected frame results are pushed to a
// scoreboard queue when each sof is driven and popped one cycle later when the
// registered outputs appear. Build with +define+GIF_PINGPONG_EN to exercise
// the bounce sequence.
// -----------------------------------------------------------------------------
module tb_gif_frame_sequencer;

   localparam int NF = 4;
   localparam int FW = 57280;
   localparam int AW = 19;
   localparam int IW = 4;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   gif_seq_if #(.IDX_W(IW), .ADDR_W(AW)) bus ();

   gif_frame_sequencer #(
      .NUM_FRAMES (NF),
      .FRAME_WORDS(FW),
      .ADDR_W     (AW),
      .IDX_W      (IW),
      .AUTOPLAY   (1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      int idx;
      int base;
      int tick;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_idx  = 0;
   int   m_dir  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   // Reference frame order: wrap 0..NF-1, or bounce when ping-pong is built in.
   function automatic void model_adv();
`ifdef GIF_PINGPONG_EN
      if (NF == 1) begin
         m_idx = 0;
      end else if (m_dir == 0) begin
         if (m_idx == NF - 1) begin m_dir = 1; m_idx = m_idx - 1; end
         else m_idx = m_idx + 1;
      end else begin
         if (m_idx == 0) begin m_dir = 0; m_idx = 1; end
         else m_idx = m_idx - 1;
      end
`else
      m_idx = (m_idx + 1) % NF;
`endif
   endfunction

   // kind: 0 = no change expected, 1 = advance expected, 2 = zeroing expected
   task automatic do_sof(input int kind, input string tag);
      exp_t e;
      e.tick = 0;
      if (kind == 1) begin
         model_adv();
         e.tick = 1;
      end else if (kind == 2) begin
         e.tick = (m_idx != 0) ? 1 : 0;
         m_idx  = 0;
         m_dir  = 0;
      end
      e.idx  = m_idx;
      e.base = m_idx * FW;
      sb.push_back(e);
      bus.h_cnt = 11'd0;
      bus.v_cnt = 11'd0;
      cyc();
      bus.h_cnt = 11'd7;
      bus.v_cnt = 11'd2;
      e = sb.pop_front();
      chk({tag, "_idx"},  32'(bus.frame_idx),  e.idx);
      chk({tag, "_base"}, 32'(bus.frame_base), e.base);
      chk({tag, "_tick"}, 32'(bus.frame_tick), e.tick);
      cyc();
      chk({tag, "_tick_off"}, 32'(bus.frame_tick), 0);
      idle(2);
   endtask

   task automatic cmd(input logic pl, input logic pa, input logic st, input logic sp);
      bus.play  = pl;
      bus.pause = pa;
      bus.stop  = st;
      bus.step  = sp;
      cyc();
      bus.play  = 1'b0;
      bus.pause = 1'b0;
      bus.stop  = 1'b0;
      bus.step  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      bus.h_cnt = 11'd7;
      bus.v_cnt = 11'd2;
      bus.play  = 1'b0;
      bus.pause = 1'b0;
      bus.stop  = 1'b0;
      bus.step  = 1'b0;
      bus.speed = 4'd0;
      idle(3);
      chk("rst_idx",     32'(bus.frame_idx),  0);
      chk("rst_base",    32'(bus.frame_base), 0);
      chk("rst_tick",    32'(bus.frame_tick), 0);
      chk("rst_playing", 32'(bus.playing),    1);
      rst_n = 1'b1;
      idle(2);

      // Free-running playback, one advance per sof.
      for (int i = 0; i < 5; i++) do_sof(1, "free");

      // Divider: speed=2 advances on every third sof.
      bus.speed = 4'd2;
      do_sof(0, "div_a");
      do_sof(0, "div_b");
      do_sof(1, "div_c");
      do_sof(0, "div_d");
      bus.speed = 4'd0;   // mid-frame change, takes effect at next sof
      do_sof(1, "div_e");
      do_sof(1, "div_f");

      // Pause and single-step.
      cmd(1'b0, 1'b1, 1'b0, 1'b0);
      chk("pause_playing", 32'(bus.playing), 0);
      cmd(1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      cmd(1'b0, 1'b0, 1'b0, 1'b1);
      chk("step_hold_idx", 32'(bus.frame_idx), m_idx);
      do_sof(1, "step_adv");
      do_sof(0, "step_none");
      cmd(1'b0, 1'b1, 1'b0, 1'b0);
      chk("resume_playing", 32'(bus.playing), 1);
      do_sof(1, "resume_adv");

      // Stop: outputs hold until the next sof, then zero with one tick.
      cmd(1'b0, 1'b0, 1'b1, 1'b0);
      chk("stop_playing",  32'(bus.playing),   0);
      chk("stop_hold_idx", 32'(bus.frame_idx), m_idx);
      do_sof(2, "stop_zero");
      do_sof(0, "stop_idle_a");
      do_sof(0, "stop_idle_b");
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      chk("play_playing", 32'(bus.playing), 1);
      do_sof(1, "play_adv");

      // Command priority.
      cmd(1'b1, 1'b0, 1'b1, 1'b0);
      chk("stop_over_play", 32'(bus.playing), 0);
      do_sof(2, "prio_zero");
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      chk("prio_play", 32'(bus.playing), 1);
      cmd(1'b1, 1'b1, 1'b0, 1'b0);
      chk("pause_over_play", 32'(bus.playing), 0);
      do_sof(0, "prio_paused");
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      chk("prio_replay", 32'(bus.playing), 1);

      // Run to the last frame, then reset asynchronously mid-frame.
      do_sof(1, "pre_rst_a");
      do_sof(1, "pre_rst_b");
      do_sof(1, "pre_rst_c");
      chk("pre_rst_idx", 32'(bus.frame_idx), NF - 1);
      rst_n = 1'b0;
      #2;
      chk("async_idx",     32'(bus.frame_idx),  0);
      chk("async_base",    32'(bus.frame_base), 0);
      chk("async_tick",    32'(bus.frame_tick), 0);
      chk("async_playing", 32'(bus.playing),    1);
      cyc();
      rst_n = 1'b1;
      m_idx = 0;
      m_dir = 0;
      idle(2);

      // Long run covering wrap (or bounce when ping-pong is built in).
      for (int i = 0; i < 7; i++) do_sof(1, "seq");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gif_frame_sequencer.md
Name: gif_frame_sequencer

Overview:
Controls animated-GIF playback for the bouncing-image display path. It chooses which stored frame the image ROM serves by producing a frame base address, which the display datapath adds to its per-pixel offset. Frame changes happen only at raster start-of-frame, so a frame never switches partway through the scan. Playback is controlled by play, pause, stop and single-step command pulses, with a programmable frame-rate divider.

Parameters:
NUM_FRAMES, 4, number of stored frames; minimum 1.
FRAME_WORDS, 57280, ROM words per frame (320x179).
ADDR_W, 19, frame_base width; NUM_FRAMES*FRAME_WORDS must be at most 2^ADDR_W.
IDX_W, 4, frame_idx width; NUM_FRAMES must be at most 2^IDX_W.
AUTOPLAY, 1, 1: leave reset in PLAY; 0: leave reset in STOP.

Ports:
clk  in  1  pixel clock, the same clock that drives h_cnt/v_cnt.
rst_n  in  1  asynchronous, active-low reset.
h_cnt  in  11  raster horizontal counter.
v_cnt  in  11  raster vertical counter.
play  in  1  1-cycle command pulse.
pause  in  1  1-cycle command pulse.
stop  in  1  1-cycle command pulse.
step  in  1  1-cycle command pulse.
speed  in  4  frames shown per GIF frame, minus 1.
frame_idx  out  IDX_W  current frame number.
frame_base  out  ADDR_W  frame_idx*FRAME_WORDS.
frame_tick  out  1  1-cycle pulse when frame_idx/frame_base change.
playing  out  1  high when the FSM is in PLAY.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state is registered.
- Start of frame: sof = (h_cnt==0 && v_cnt==0), decoded combinationally. It is high for exactly 1 clk per frame.
- Reset values:
  - frame_idx=0, frame_base=0, frame_tick=0.
  - div_cnt=0, step_pend=0, dir=forward.
  - State = PLAY if AUTOPLAY, else STOP. playing reflects the state (=AUTOPLAY).
  - An async reset mid-frame or mid-divide takes effect immediately. Pending step and partial divide count are discarded.
- FSM states: STOP, PLAY, PAUSE. Command transitions are taken on the cycle the pulse arrives, independent of sof.
  - stop: any state -> STOP; sets zero_pend.
  - pause: PLAY -> PAUSE; PAUSE -> PLAY (toggle); ignored in STOP.
  - play: STOP/PAUSE -> PLAY.
  - Simultaneous commands: priority is stop > pause > play. Only the highest-priority command acts.
  - playing is registered and is updated the cycle after the command.
- PLAY, on each sof:
  - If div_cnt >= speed: advance one frame and set div_cnt=0.
  - Otherwise div_cnt+1.
  - speed is sampled at sof, so a change mid-frame is harmless. speed=0 advances every frame; speed=15 advances every 16th frame.
- PAUSE:
  - step pulse sets step_pend. Multiple steps within one frame collapse to one.
  - At sof with step_pend=1: advance one frame, clear step_pend, leave div_cnt unchanged.
  - step is ignored in PLAY and STOP. step_pend is cleared on leaving PAUSE.
- STOP:
  - At sof with zero_pend=1: frame_idx=0, frame_base=0, dir=forward, div_cnt=0. Clear zero_pend and pulse frame_tick, but only if frame_idx was nonzero.
  - No further changes while in STOP.
- Advance (forward):
  - If frame_idx==NUM_FRAMES-1: frame_idx=0, frame_base=0.
  - Otherwise frame_idx+1, frame_base+FRAME_WORDS.
  - frame_base is updated incrementally (add/subtract FRAME_WORDS, reset to 0 on wrap); no multiplier.
- Timing: frame_idx, frame_base and frame_tick are registered together and change the cycle after sof, i.e. 1-cycle latency. frame_tick is high for exactly that one cycle.
- NUM_FRAMES=1: an advance keeps idx=0 and base=0, and frame_tick still pulses.
- frame_base is never outside [0, (NUM_FRAMES-1)*FRAME_WORDS].

Optional Feature:
Macro GIF_PINGPONG_EN.
- Defined: advance uses the dir register.
  - Forward at idx NUM_FRAMES-1: flip dir to backward, go to NUM_FRAMES-2.
  - Backward at idx 0: flip dir to forward, go to 1.
  - Sequence for NUM_FRAMES=4 is 0,1,2,3,2,1,0,1,...
  - NUM_FRAMES=1 stays at 0; NUM_FRAMES=2 alternates 0,1.
  - STOP resets dir to forward.
- Undefined: no dir register; forward wrap as described in Behaviour.

Test Plan:
- Free-running playback: AUTOPLAY=1, NUM_FRAMES=4, speed=0, 5 sofs -> frame_idx 1,2,3,0,1 and frame_base 57280,114560,171840,0,57280. frame_tick is high 1 cycle after each sof.
- Frame divider: speed=2 -> idx advances only on every 3rd sof. Changing speed mid-frame to 0 takes effect at the next sof.
- Pause and step: pause, then 2 step pulses mid-frame -> no change until sof, then exactly one advance. A further sof with no step -> no change. Pause again -> resumes PLAY.
- Stop: stop at idx=2 -> playing=0 next cycle, idx=0 and base=0 after next sof with one frame_tick. Further sofs -> no ticks. play -> advancing resumes.
- Command priority and reset: stop+play in the same cycle -> STOP. pause+play in PLAY -> PAUSE. rst_n low mid-frame at idx=3 -> all outputs 0 immediately, playing=1.
- Ping-pong (GIF_PINGPONG_EN), speed=0 -> idx 1,2,3,2,1,0,1 over 7 sofs, with base tracking idx*57280.
